// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB RAM completer: FSM state encoding,
// pprot bit positions and the byte-lane merge used by the RAM write path.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int APB_PROT_PRIV   = 0;
  localparam int APB_PROT_NONSEC = 1;
  localparam int APB_PROT_INSTR  = 2;

  // Sized for the widest legal bus (64 bits); narrower callers zero-extend.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_dat,
                                             input logic [63:0] new_dat,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_dat;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_dat[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// Single-port byte-write RAM; write on the edge with we=1, read data registered
// one edge after rd_en and forced to 0 on any edge without rd_en.
module apb_ram_mem
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] strb,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [63:0]       merged;
  logic              unused_merged;

  always_comb merged = strb_merge(64'(mem[addr]), 64'(wdata), 8'(strb));
  assign unused_merged = ^merged;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merged[DATA_W-1:0];
  end

  // Zero whenever no read is being returned, so the bus sees 0 outside pready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
    else            rdata <= '0;
  end

endmodule

// File: rtl/apb_ram.sv
// APB completer over a byte-writable word RAM; pready rises WAIT_CYCLES+1 cycles
// after the setup phase, for one cycle; out-of-range/unprivileged access -> pslverr.
module apb_ram
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int STRB_W      = DATA_W / 8,
  parameter int MEM_ADDR_W  = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_apb_paddr,
  input  logic [2:0]        s_apb_pprot,
  input  logic              s_apb_psel,
  input  logic              s_apb_penable,
  input  logic              s_apb_pwrite,
  input  logic [DATA_W-1:0] s_apb_pwdata,
  input  logic [STRB_W-1:0] s_apb_pstrb,
  output logic              s_apb_pready,
  output logic [DATA_W-1:0] s_apb_prdata,
  output logic              s_apb_pslverr
);

  localparam int         LSB       = $clog2(STRB_W);
  localparam int         IDX_HI    = MEM_ADDR_W + LSB;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                state;
  logic [3:0]            cnt;
  logic [MEM_ADDR_W-1:0] idx_in, idx_q, mem_addr;
  logic                  oor, err_in, err_q, err_cur;
  logic                  pready_q, pslverr_q;
  logic                  setup, go_done, rd_en, we;
  logic                  unused_bits;

  assign idx_in = s_apb_paddr[IDX_HI-1:LSB];

  generate
    if (ADDR_W > IDX_HI) begin : g_range
      assign oor = |s_apb_paddr[ADDR_W-1:IDX_HI];
    end else begin : g_no_range
      assign oor = 1'b0;
    end
  endgenerate

  assign err_in      = oor | ((PRIV_ONLY != 0) & ~s_apb_pprot[APB_PROT_PRIV]);
  assign unused_bits = ^{s_apb_paddr, s_apb_pprot};
  assign setup       = s_apb_psel & ~s_apb_penable;

  // go_done marks the edge that raises pready; the RAM read is launched on it.
  always_comb begin
    go_done = 1'b0;
    err_cur = err_q;
    case (state)
      ST_IDLE: begin
        go_done = setup && (WAIT_CYCLES == 0);
        err_cur = err_in;
      end
      ST_WAIT: go_done = s_apb_psel && (cnt == 4'd0);
      default: ;
    endcase
  end

  assign rd_en    = go_done & ~err_cur & ~s_apb_pwrite;
  assign we       = (state == ST_DONE) & s_apb_psel & s_apb_penable & pready_q
                    & s_apb_pwrite & ~err_q;
  assign mem_addr = (state == ST_IDLE) ? idx_in : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (setup) begin
            idx_q <= idx_in;
            err_q <= err_in;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_DONE;
              pready_q  <= 1'b1;
              pslverr_q <= err_in;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          // Losing psel mid-transfer abandons it; nothing is written.
          if (!s_apb_psel) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state     <= ST_DONE;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  apb_ram_mem #(
    .DATA_W (DATA_W),
    .STRB_W (STRB_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .addr  (mem_addr),
    .we    (we),
    .wdata (s_apb_pwdata),
    .strb  (s_apb_pstrb),
    .rd_en (rd_en),
    .rdata (s_apb_prdata)
  );

  assign s_apb_pready  = pready_q;
  assign s_apb_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram.sv
// Bench for apb_ram: three instances (0 wait states, 3 wait states, privileged-only)
// share one APB bus with separate psel, checked against a word-array model.
module tb_apb_ram;

  logic        clk;
  logic        rst;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready [3];
  logic [31:0] prdata [3];
  logic        pslverr [3];

  int wait_of [3] = '{0, 3, 0};
  int priv_of [3] = '{0, 0, 1};

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [3][16];

  apb_ram #(.WAIT_CYCLES(0), .PRIV_ONLY(0)) dut0 (
    .clk(clk), .rst(rst), .s_apb_paddr(paddr), .s_apb_pprot(pprot),
    .s_apb_psel(psel[0]), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[0]),
    .s_apb_prdata(prdata[0]), .s_apb_pslverr(pslverr[0]));

  apb_ram #(.WAIT_CYCLES(3), .PRIV_ONLY(0)) dut1 (
    .clk(clk), .rst(rst), .s_apb_paddr(paddr), .s_apb_pprot(pprot),
    .s_apb_psel(psel[1]), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[1]),
    .s_apb_prdata(prdata[1]), .s_apb_pslverr(pslverr[1]));

  apb_ram #(.WAIT_CYCLES(0), .PRIV_ONLY(1)) dut2 (
    .clk(clk), .rst(rst), .s_apb_paddr(paddr), .s_apb_pprot(pprot),
    .s_apb_psel(psel[2]), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pready(pready[2]),
    .s_apb_prdata(prdata[2]), .s_apb_pslverr(pslverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at #1 after an edge; returns at #1 after the completing edge with psel low.
  task automatic xfer(input int d, input logic wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er, output int lat);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = prot;
    psel[d] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (pready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL xfer_timeout dut%0d addr=%h: pready=%b required=1", d, addr, pready[d]);
    end
    rd = prdata[d];
    er = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h required 0/0/0",
                 d, pready[d], pslverr[d], prdata[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle dut%0d: pready=%b pslverr=%b required 0/0", d, pready[d], pslverr[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, lat);
    n_checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_write: lat=%0d err=%b rd=%h required 1/0/0", lat, er, rd);
    end
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_read: lat=%0d err=%b rd=%h required 1/0/deadbeef", lat, er, rd);
    end
    n_checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_after: pready=%b prdata=%h required 0/0", pready[0], prdata[0]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    xfer(1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, lat);
    n_checks++;
    if (lat !== 4 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_write: lat=%0d err=%b required 4/0", lat, er);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (lat !== 4 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_read: lat=%0d rd=%h err=%b required 4/deadbeef/0", lat, rd, er);
    end
    n_checks++;
    if (pready[1] !== 1'b0 || prdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wait_single_cycle: pready=%b prdata=%h required 0/0", pready[1], prdata[1]);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'h0010, 32'h11223344, 4'h5, 3'b001, rd, er, lat);
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_merge: rd=%h err=%b required de22be44/0", rd, er);
    end
    xfer(0, 1'b1, 16'h0012, 32'h99999999, 4'h0, 3'b001, rd, er, lat);
    xfer(0, 1'b0, 16'h0013, 32'h0, 4'hF, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_zero: rd=%h err=%b required de22be44/0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'h0000, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, lat);
    xfer(0, 1'b1, 16'h0400, 32'h00000055, 4'hF, 3'b001, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++;
      $display("FAIL oor_write: err=%b rd=%h lat=%0d required 1/0/1", er, rd, lat);
    end
    xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_no_alias: rd=%h err=%b required a5a5a5a5/0", rd, er);
    end
    xfer(0, 1'b0, 16'h8000, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_read: err=%b rd=%h required 1/0", er, rd);
    end
  endtask

  task automatic test_priv();
    logic [31:0] rd; logic er; int lat;
    xfer(2, 1'b1, 16'h0010, 32'h0BADF00D, 4'hF, 3'b001, rd, er, lat);
    xfer(2, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL priv_reject: err=%b rd=%h required 1/0", er, rd);
    end
    xfer(2, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 3'b110, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin
      n_fail++;
      $display("FAIL priv_write_reject: err=%b required 1", er);
    end
    xfer(2, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL priv_accept: err=%b rd=%h required 0/0badf00d", er, rd);
    end
  endtask

  task automatic test_idle_enable();
    logic seen;
    logic [31:0] rd; logic er; int lat;
    seen = 1'b0;
    paddr = 16'h0010; pwrite = 1'b0; pprot = 3'b001;
    psel[0] = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (pready[0] === 1'b1) seen = 1'b1;
    end
    psel[0] = 1'b0; penable = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_penable_ignored: pready_seen=%b required 0", seen);
    end
    @(posedge clk); #1;
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (lat !== 1 || rd !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL idle_penable_recover: lat=%0d rd=%h required 1/de22be44", lat, rd);
    end
  endtask

  task automatic test_abort();
    logic seen;
    logic [31:0] rd; logic er; int lat;
    xfer(1, 1'b1, 16'h0020, 32'h600DCAFE, 4'hF, 3'b001, rd, er, lat);
    paddr = 16'h0020; pwrite = 1'b1; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    psel[1] = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pready[1] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_pready: pready_seen=%b required 0", seen);
    end
    xfer(1, 1'b0, 16'h0020, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'h600DCAFE || lat !== 4 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_write: rd=%h lat=%0d err=%b required 600dcafe/4/0", rd, lat, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    xfer(0, 1'b1, 16'h0030, 32'h13579BDF, 4'hF, 3'b001, rd, er, lat);
    paddr = 16'h0030; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    psel[0] = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    n_checks++;
    if (pready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pready_before: pready=%b required 1", pready[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: pready=%b pslverr=%b prdata=%h required 0/0/0",
               pready[0], pslverr[0], prdata[0]);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 16'h0030, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'h13579BDF || lat !== 1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_write: rd=%h lat=%0d err=%b required 13579bdf/1/0", rd, lat, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    // Consecutive calls start the next setup in the cycle right after pready.
    xfer(0, 1'b1, 16'h0034, 32'h01020304, 4'hF, 3'b001, rd, er, lat);
    xfer(0, 1'b1, 16'h0034, 32'hAABBCCDD, 4'hC, 3'b001, rd, er, lat);
    xfer(0, 1'b0, 16'h0034, 32'h0, 4'h0, 3'b001, rd, er, lat);
    n_checks++;
    if (rd !== 32'hAABB0304 || lat !== 1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_raw: rd=%h lat=%0d err=%b required aabb0304/1/0", rd, lat, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd;
    logic [15:0] addr;
    logic [3:0]  st;
    logic [2:0]  prot;
    logic        er, wr, exp_er;
    int          lat, w;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        xfer(d, 1'b1, 16'(i * 4), wd, 4'hF, 3'b001, rd, er, lat);
        mdl[d][i] = wd;
      end
      for (int n = 0; n < 60; n++) begin
        w    = $urandom_range(0, 15);
        addr = 16'(w * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) addr[15:10] = 6'($urandom_range(1, 63));
        wr   = 1'($urandom_range(0, 1));
        wd   = $urandom;
        st   = 4'($urandom_range(0, 15));
        prot = 3'($urandom_range(0, 7));
        exp_er = (addr[15:10] != 6'd0) || (priv_of[d] != 0 && prot[0] == 1'b0);
        exp_rd = (wr || exp_er) ? 32'h0 : mdl[d][w];
        xfer(d, wr, addr, wd, st, prot, rd, er, lat);
        if (wr && !exp_er) begin
          for (int b = 0; b < 4; b++) begin
            if (st[b]) mdl[d][w][b*8 +: 8] = wd[b*8 +: 8];
          end
        end
        n_checks++;
        if (rd !== exp_rd || er !== exp_er || lat !== 1 + wait_of[d]) begin
          n_fail++;
          $display("FAIL random dut%0d wr=%b addr=%h strb=%h prot=%b: rd=%h err=%b lat=%0d required %h/%b/%0d",
                   d, wr, addr, st, prot, rd, er, lat, exp_rd, exp_er, 1 + wait_of[d]);
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) psel[d] = 1'b0;
    paddr = '0; pprot = 3'b001; penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
    test_reset();
    test_basic();
    test_wait_states();
    test_strobes();
    test_out_of_range();
    test_priv();
    test_idle_enable();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_ram.md
Name: apb_ram

Overview:
- APB completer backed by a byte-writable word RAM.
- Sits directly downstream of the APB requester on the test APB interface and consumes its transfers.
- Provides programmable wait states, byte strobes, and error responses for out-of-range or unprivileged accesses.
- Used as the reference target when exercising the APB requester model.

Parameters:
- DATA_W, 32, data bus width; must be 8, 16, 32 or 64.
- ADDR_W, 16, byte address width of s_apb_paddr.
- STRB_W, DATA_W/8, strobe width.
- MEM_ADDR_W, 8, log2 of RAM depth in words.
- WAIT_CYCLES, 0, wait states inserted per access; range 0..15.
- PRIV_ONLY, 0, when 1 an access with pprot[0]=0 (unprivileged) is rejected with pslverr.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- s_apb_paddr  in  ADDR_W  byte address.
- s_apb_pprot  in  3  protection attributes.
- s_apb_psel  in  1  select.
- s_apb_penable  in  1  access phase.
- s_apb_pwrite  in  1  1 = write.
- s_apb_pwdata  in  DATA_W  write data.
- s_apb_pstrb  in  STRB_W  byte-lane write strobes.
- s_apb_pready  out  1  transfer complete.
- s_apb_prdata  out  DATA_W  read data.
- s_apb_pslverr  out  1  error response.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, pready=0, prdata=0, pslverr=0, wait counter=0.
  - RAM contents are not reset and are undefined until written.
- All outputs are registered.
- Word index = paddr[MEM_ADDR_W+log2(STRB_W)-1 : log2(STRB_W)]; low address bits are ignored.
- Error condition, evaluated at the setup phase:
  - any paddr bit at or above MEM_ADDR_W+log2(STRB_W) is set (out of range), or
  - PRIV_ONLY=1 and pprot[0]=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On psel=1 and penable=0 (setup phase at cycle T), latch the error flag and word index.
  - If WAIT_CYCLES=0: go to DONE and register pready=1 with response data, so pready=1 in cycle T+1.
  - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle.
  - At counter=0: go to DONE and register pready=1 with response data.
  - Result: pready is first high in cycle T+1+WAIT_CYCLES.
- DONE:
  - pready=1 for exactly one cycle; the transfer completes on this edge.
  - Next state is IDLE, with pready, pslverr and prdata cleared to 0.
  - A new setup phase may be presented in the cycle immediately after pready, giving back-to-back transfers with no idle cycle.
- Write: the RAM updates only on the completing edge (psel & penable & pready) and only if error=0.
  - Byte lane i is written iff pstrb[i]=1.
  - pstrb=0 completes without changing memory.
- Read:
  - prdata is valid only while pready=1; it is 0 otherwise and 0 on error.
  - pstrb is ignored on reads.
- Error response: pslverr=1 only while pready=1; no memory side effect.
- Protocol violation: psel falls before completion → abort to IDLE, no write, outputs cleared next cycle.
- penable=1 while in IDLE (no preceding setup phase) is ignored.
- Reset asserted mid-transfer: immediate return to IDLE with outputs 0; any pending write is dropped.
- Read-after-write to the same word in consecutive transfers returns the new data.

Decomposition:
- apb_pkg holds:
  - FSM state enum;
  - APB_PROT_PRIV, APB_PROT_NONSEC and APB_PROT_INSTR bit-index constants;
  - function strb_merge(old, new, strb) for byte merging.
- Sub-module apb_ram_mem: single-port byte-write RAM with registered read; instantiated once.
- FSM and decode stay in apb_ram.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x0010 with pstrb=0xF, then read 0x0010 → pready at T+1 each, prdata=0xDEADBEEF, pslverr=0.
- WAIT_CYCLES=3: read 0x0010 → pready first high at T+4, held 1 cycle, then 0.
- Byte strobes: write 0x11223344 with pstrb=0x5 over 0xDEADBEEF → read returns 0xDE22BE44.
- Out-of-range: MEM_ADDR_W=8, write 0x55 to 0x0400 → pslverr=1 with pready, prdata=0; a following read of 0x0000 is unchanged.
- PRIV_ONLY=1: read with pprot=3'b000 → pslverr=1; the same read with pprot=3'b001 → data, pslverr=0.
- Abort/reset: drop psel during WAIT, or assert rst mid-write → no memory update, pready=0; the next transfer completes normally.
